// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV64 pipeline.
// Load-use bubbles, branch flushes, data-memory freeze with a timeout watchdog.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             mem_Branch,
  input  logic             mem_zero,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pipe_en,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pc_sel_branch,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       stall_mem, taken, load_use;
  logic       rs1_hit, rs2_hit, err;
  logic       stall_inc, flush_inc;

  assign stall_mem = dmem_req & ~dmem_ready;
  assign taken     = mem_Branch & mem_zero;
  assign rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use  = ex_MemRead & (ex_rd != 5'd0)
                   & (rs1_hit | rs2_hit);
  assign err       = (state == ERR);

  assign stall_inc = ~err & (stall_mem | (load_use & ~taken));
  assign flush_inc = ~err & taken & ~stall_mem;
  assign mem_timeout = err;

  // A frozen pipeline holds any pending branch or hazard for re-evaluation.
  always_comb begin
    pipe_en       = 1'b1;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    if (err || stall_mem) begin
      pipe_en    = 1'b0;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (taken) begin
      pc_sel_branch = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (!err) begin
      if (stall_mem) begin
        if (wait_cnt == LAST) begin
          state_nxt = ERR;
        end else begin
          state_nxt = MEM_WAIT;
          wait_nxt  = wait_cnt + 8'd1;
        end
      end else begin
        state_nxt = RUN;
        wait_nxt  = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_inc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + ONE;
      if (flush_inc && (flush_events != '1))
        flush_events <= flush_events + ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, corner sequences,
// and random stimulus against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_MemRead;
  logic          mem_Branch, mem_zero, dmem_req, dmem_ready;
  logic          pipe_en, pc_write, ifid_write, pc_sel_branch;
  logic          ifid_flush, idex_flush, exmem_flush, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [6:0]    ctrl;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .mem_Branch(mem_Branch), .mem_zero(mem_zero),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pipe_en(pipe_en), .pc_write(pc_write),
    .ifid_write(ifid_write), .pc_sel_branch(pc_sel_branch),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign ctrl = {pipe_en, pc_write, ifid_write, pc_sel_branch,
                 ifid_flush, idex_flush, exmem_flush};

  localparam logic [6:0] C_IDLE = 7'b1110000;
  localparam logic [6:0] C_LU   = 7'b1000010;
  localparam logic [6:0] C_BR   = 7'b1111111;
  localparam logic [6:0] C_FRZ  = 7'b0000000;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, zr, req, rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[10];

  int n_vec = 0;
  int n_err = 0;

  int m_wait, m_stall, m_flush;
  bit m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit r_stall();
    return dmem_req && !dmem_ready;
  endfunction

  function automatic bit r_taken();
    return mem_Branch && mem_zero;
  endfunction

  function automatic bit r_lu();
    bit h1, h2;
    h1 = id_uses_rs1 && (id_rs1 == ex_rd);
    h2 = id_uses_rs2 && (id_rs2 == ex_rd);
    return ex_MemRead && (ex_rd != 0) && (h1 || h2);
  endfunction

  function automatic logic [6:0] exp_ctrl();
    if (m_err || r_stall()) return C_FRZ;
    if (r_taken()) return C_BR;
    if (r_lu()) return C_LU;
    return C_IDLE;
  endfunction

  task automatic model_clear();
    m_wait = 0;
    m_stall = 0;
    m_flush = 0;
    m_err = 0;
  endtask

  // Count consecutive stalled edges; the MT-th one is fatal.
  task automatic model_edge();
    bit sm, tk, lu;
    sm = r_stall();
    tk = r_taken();
    lu = r_lu();
    if (!m_err) begin
      if (sm || (lu && !tk)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (tk && !sm) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (sm) begin
        m_wait++;
        if (m_wait == MT) m_err = 1;
      end else begin
        m_wait = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("ctrl", 32'(ctrl), 32'(exp_ctrl()));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_err));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("flush_events", 32'(flush_events), 32'(m_flush));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_MemRead = 0; mem_Branch = 0; mem_zero = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic set_lu();
    ex_MemRead = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_MemRead = v.mr;
    mem_Branch = v.br; mem_zero = v.zr;
    dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  initial begin
    tbl[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};
    tbl[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU};
    tbl[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};
    tbl[3] = '{5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};
    tbl[4] = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU};
    tbl[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_BR};
    tbl[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE};
    tbl[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_FRZ};
    tbl[8] = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, C_LU};
    tbl[9] = '{5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};

    idle();
    reset = 1'b1;
    model_clear();
    #3;
    chk("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("reset_flush_cnt", 32'(flush_events), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      apply(tbl[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(ctrl), 32'(tbl[i].exp));
      cycle();
    end

    // single load-use bubble, then ex_rd=0 never stalls
    do_reset();
    set_lu();
    cycle();
    idle();
    #2;
    chk("lu_after_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    set_lu();
    ex_rd = 0; id_rs1 = 0;
    cycle();
    #2;
    chk("lu_x0_stall_cnt", 32'(stall_cycles), 32'd1);

    // branch squashes the load-use
    do_reset();
    set_lu();
    mem_Branch = 1; mem_zero = 1;
    cycle();
    idle();
    #2;
    chk("br_flush_cnt", 32'(flush_events), 32'd1);
    chk("br_stall_cnt", 32'(stall_cycles), 32'd0);
    mem_Branch = 1;
    #1;
    chk("br_notaken_ctrl", 32'(ctrl), 32'(C_IDLE));
    cycle();

    // memory wait holds the branch, then flushes on ready
    do_reset();
    mem_Branch = 1; mem_zero = 1; dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("mw_freeze", 32'(pipe_en), 32'd0);
      cycle();
    end
    dmem_ready = 1;
    #2;
    chk("mw_flush_ctrl", 32'(ctrl), 32'(C_BR));
    cycle();
    idle();
    #2;
    chk("mw_stall_cnt", 32'(stall_cycles), 32'd3);
    chk("mw_flush_cnt", 32'(flush_events), 32'd1);
    chk("mw_run", 32'(pipe_en), 32'd1);
    cycle();

    // timeout, sticky ERR, asynchronous reset recovery
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (MT) cycle();
    #2;
    chk("to_flag", 32'(mem_timeout), 32'd1);
    chk("to_freeze", 32'(pipe_en), 32'd0);
    dmem_ready = 1;
    cycle();
    idle();
    cycle();
    #2;
    chk("to_sticky_flag", 32'(mem_timeout), 32'd1);
    chk("to_sticky_ctrl", 32'(ctrl), 32'(C_FRZ));
    reset = 1'b1;
    #1;
    chk("to_rst_flag", 32'(mem_timeout), 32'd0);
    chk("to_rst_run", 32'(pipe_en), 32'd1);
    chk("to_rst_cnt", 32'(stall_cycles), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // near-miss: a single ready cycle restarts the watchdog
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (MT - 1) cycle();
    dmem_ready = 1;
    cycle();
    dmem_ready = 0;
    repeat (MT - 1) cycle();
    #2;
    chk("nm_no_timeout", 32'(mem_timeout), 32'd0);
    idle();
    cycle();

    // stall counter saturation
    do_reset();
    set_lu();
    repeat (20) cycle();
    #2;
    chk("sat_stall_cnt", 32'(stall_cycles), 32'(CMAX));
    idle();

    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_MemRead = 1'($urandom_range(0, 1));
      mem_Branch = 1'($urandom_range(0, 1));
      mem_zero = 1'($urandom_range(0, 1));
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 64-bit 5-stage RISC-V pipeline.
- Detects load-use hazards between the ID and EX stages.
- Applies branch-taken flushes when a branch resolves in the MEM stage (EX/MEM Branch & zero).
- Freezes the whole pipeline while the data memory is busy, using a req/ready handshake with a timeout watchdog.
- Drives the enable and flush inputs of PC, IF/ID, ID/EX and EX/MEM, and keeps saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, consecutive data-memory wait cycles before a fatal timeout; legal range 2..255
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of the instruction in EX (ID/EX output)
ex_MemRead  in  1  EX instruction is a load
mem_Branch  in  1  Branch bit from the EX/MEM register
mem_zero  in  1  zero flag from the EX/MEM register
dmem_req  in  1  MEM stage accessing data memory (MemRead|MemWrite)
dmem_ready  in  1  data memory completes the access this cycle
pipe_en  out  1  global enable for PC and all pipeline registers; 0 = freeze
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
pc_sel_branch  out  1  select branch target for the next PC
ifid_flush  out  1  IF/ID loads a bubble
idex_flush  out  1  ID/EX loads a bubble (control bits cleared)
exmem_flush  out  1  EX/MEM loads a bubble
mem_timeout  out  1  sticky fatal error flag
stall_cycles  out  CNT_W  saturating count of stall cycles
flush_events  out  CNT_W  saturating count of branch flushes

Behaviour:
- Reset is asynchronous, active-high. It sets state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
- With idle inputs during or after reset, the outputs are: pipe_en=1, pc_write=1, ifid_write=1, pc_sel_branch=0, all flushes 0.
- Internal terms (combinational):
  - stall_mem = dmem_req & ~dmem_ready
  - taken = mem_Branch & mem_zero
  - load_use = ex_MemRead & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- The control outputs are combinational from state and the current inputs. There is no added latency.
- Priority in RUN and MEM_WAIT, highest first:
  1. stall_mem: pipe_en=0, pc_write=0, ifid_write=0, all flushes 0. A pending taken or load_use is held and evaluated again on the cycle dmem_ready=1.
  2. taken: pc_sel_branch=1, ifid_flush=1, idex_flush=1, exmem_flush=1; pc_write=1, ifid_write=1. A simultaneous load_use is ignored because the ID instruction is squashed.
  3. load_use: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble per hazard; on the next cycle the load is in MEM and the condition clears naturally.
  4. Otherwise: all enables 1, all flushes 0.
- State machine (RUN, MEM_WAIT, ERR), transitions at the clock edge:
  - RUN or MEM_WAIT, stall_mem=1:
    - if wait_cnt==MEM_TIMEOUT-1, go to ERR;
    - else wait_cnt+1 and go to MEM_WAIT.
  - RUN or MEM_WAIT, stall_mem=0: wait_cnt=0, go to RUN.
  - ERR: sticky until reset. pipe_en=0, pc_write=0, ifid_write=0, flushes 0, mem_timeout=1. All inputs are ignored.
- Timeout boundary: exactly MEM_TIMEOUT consecutive stalled edges reach ERR. A single ready cycle clears wait_cnt.
- stall_cycles increments on each edge where state≠ERR and (stall_mem | (load_use & ~taken)). It saturates at 2^CNT_W−1.
- flush_events increments on each edge where state≠ERR and taken & ~stall_mem. It saturates at 2^CNT_W−1.
- Reset mid-stall or in ERR returns to RUN immediately (asynchronous) and clears the counters.
- ex_rd=0 never causes a stall.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1. Same with ex_rd=0 → no stall.
- Branch: mem_Branch=1, mem_zero=1 together with a load-use hazard → pc_sel_branch=1, all three flushes=1, no stall; flush_events=1. mem_zero=0 → no flush.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1, with taken=1 throughout → pipe_en=0 for 3 cycles, then flush on the ready cycle; stall_cycles=3, flush_events=1, state back to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready=0 for 4 edges → mem_timeout=1, pipe_en=0 permanently. Ready=1 afterwards → still ERR. Assert reset → mem_timeout=0, pipe_en=1.
- Timeout near-miss: 3 stalled cycles, 1 ready cycle, 3 stalled cycles (MEM_TIMEOUT=4) → no ERR.
- Saturation: CNT_W=4, 20 load-use stall cycles → stall_cycles holds at 15.
